// File: rtl/mem_system_ctrl.sv
// rtl/mem_system_ctrl.sv - ROM/RAM memory controller with wait states, byte lanes and faults
// One request at a time: IDLE -> [WAIT] -> ACCESS -> RESP, or IDLE -> RESP on a fault.
module mem_system_ctrl #(
  parameter int          DATA_WIDTH = 32,
  parameter int          ROM_DEPTH  = 64,
  parameter int          RAM_DEPTH  = 64,
  parameter logic [31:0] TEXT_BASE  = 32'h0040_0000,
  parameter logic [31:0] DATA_BASE  = 32'h1001_0000,
  parameter int          ROM_WAIT   = 0,
  parameter int          RAM_WAIT   = 1,
  parameter string       ROM_FILE   = "text.dat"
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic [1:0]            size_i,
  input  logic                  sext_i,
  input  logic [DATA_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic                  busy_o,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic [1:0]            fault_o
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_WAIT   = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  localparam int RAM_AW = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
  localparam int ROM_AW = (ROM_DEPTH > 1) ? $clog2(ROM_DEPTH) : 1;
  localparam int IDX_W  = (RAM_AW > ROM_AW) ? RAM_AW : ROM_AW;

  localparam logic [31:0] RAM_BYTES = 32'(4 * RAM_DEPTH);
  localparam logic [31:0] ROM_BYTES = 32'(4 * ROM_DEPTH);

  localparam logic [1:0] F_OK       = 2'b00;
  localparam logic [1:0] F_MISALIGN = 2'b01;
  localparam logic [1:0] F_UNMAPPED = 2'b10;
  localparam logic [1:0] F_ROMSTORE = 2'b11;

  // Built-in program image standing in for the text file; a blank name gives an all-zero ROM.
  function automatic logic [31:0] rom_word(input logic [31:0] idx);
    if (ROM_FILE == "") rom_word = 32'h0;
    else                rom_word = 32'h2008_0000 + (idx << 16) + (idx << 2) + 32'd1;
  endfunction

  logic [1:0]       r_state;
  logic [3:0]       r_cnt;
  logic             r_we;
  logic [1:0]       r_size;
  logic             r_sext;
  logic [1:0]       r_lane;
  logic             r_is_ram;
  logic [IDX_W-1:0] r_index;
  logic [31:0]      r_wdata;
  logic [31:0]      r_rdata;
  logic [1:0]       r_fault;
  logic [31:0]      r_ram [RAM_DEPTH];

  logic [31:0]      w_ram_off;
  logic [31:0]      w_rom_off;
  logic             w_ram_hit;
  logic             w_rom_hit;
  logic             w_misalign;
  logic [1:0]       w_fault;
  logic [IDX_W-1:0] w_index;
  logic [3:0]       w_wait;

  assign w_ram_off  = addr_i - DATA_BASE;
  assign w_rom_off  = addr_i - TEXT_BASE;
  assign w_ram_hit  = (addr_i >= DATA_BASE) && (w_ram_off < RAM_BYTES);
  assign w_rom_hit  = (addr_i >= TEXT_BASE) && (w_rom_off < ROM_BYTES);
  assign w_misalign = ((size_i == 2'b01) && addr_i[0]) || (size_i[1] && (addr_i[1:0] != 2'b00));
  assign w_index    = w_ram_hit ? w_ram_off[IDX_W+1:2] : w_rom_off[IDX_W+1:2];
  assign w_wait     = w_ram_hit ? 4'(RAM_WAIT) : 4'(ROM_WAIT);

  always_comb begin
    w_fault = F_OK;
    if (w_misalign)                   w_fault = F_MISALIGN;
    else if (!w_ram_hit && !w_rom_hit) w_fault = F_UNMAPPED;
    else if (w_rom_hit && we_i)       w_fault = F_ROMSTORE;
  end

  logic [31:0] w_word;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load;
  logic [3:0]  w_be;
  logic [31:0] w_wd;

  always_comb begin
    w_word = r_is_ram ? r_ram[r_index[RAM_AW-1:0]] : rom_word(32'(r_index));
    w_byte = w_word[{r_lane, 3'b000} +: 8];
    w_half = r_lane[1] ? w_word[31:16] : w_word[15:0];
    case (r_size)
      2'b00:   w_load = {{24{r_sext & w_byte[7]}}, w_byte};
      2'b01:   w_load = {{16{r_sext & w_half[15]}}, w_half};
      default: w_load = w_word;
    endcase
  end

  // Narrow stores replicate the data across lanes; the byte enables pick the target lanes.
  always_comb begin
    case (r_size)
      2'b00: begin
        w_be = 4'b0001 << r_lane;
        w_wd = {4{r_wdata[7:0]}};
      end
      2'b01: begin
        w_be = r_lane[1] ? 4'b1100 : 4'b0011;
        w_wd = {2{r_wdata[15:0]}};
      end
      default: begin
        w_be = 4'b1111;
        w_wd = r_wdata;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= 4'd0;
      r_we     <= 1'b0;
      r_size   <= 2'b00;
      r_sext   <= 1'b0;
      r_lane   <= 2'b00;
      r_is_ram <= 1'b0;
      r_index  <= '0;
      r_wdata  <= 32'h0;
      r_rdata  <= 32'h0;
      r_fault  <= F_OK;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_i) begin
            r_we     <= we_i;
            r_size   <= size_i;
            r_sext   <= sext_i;
            r_lane   <= addr_i[1:0];
            r_is_ram <= w_ram_hit;
            r_index  <= w_index;
            r_wdata  <= wdata_i;
            if (w_fault != F_OK) begin
              r_rdata <= 32'h0;
              r_fault <= w_fault;
              r_state <= S_RESP;
            end else if (w_wait == 4'd0) begin
              r_state <= S_ACCESS;
            end else begin
              r_cnt   <= w_wait;
              r_state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) r_state <= S_ACCESS;
        end
        S_ACCESS: begin
          r_rdata <= r_we ? 32'h0 : w_load;
          r_fault <= F_OK;
          r_state <= S_RESP;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // RAM has no reset; a store lands only on a non-reset edge leaving ACCESS.
  always_ff @(posedge clk) begin
    if (reset && (r_state == S_ACCESS) && r_we && r_is_ram) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) r_ram[r_index[RAM_AW-1:0]][8*b +: 8] <= w_wd[8*b +: 8];
      end
    end
  end

  assign busy_o  = (r_state != S_IDLE);
  assign valid_o = (r_state == S_RESP);
  assign rdata_o = r_rdata;
  assign fault_o = r_fault;

endmodule

// File: tb/tb_mem_system_ctrl.sv
// tb/tb_mem_system_ctrl.sv - directed vector bench for mem_system_ctrl
// Table of single requests plus hand sequences for reset-in-flight, busy pulses and back-to-back.
module tb_mem_system_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_i = 1'b0;
  logic        we_i = 1'b0;
  logic [1:0]  size_i = 2'b00;
  logic        sext_i = 1'b0;
  logic [31:0] addr_i = 32'h0;
  logic [31:0] wdata_i = 32'h0;
  logic        busy_o;
  logic        valid_o;
  logic [31:0] rdata_o;
  logic [1:0]  fault_o;

  always #5 clk = ~clk;

  mem_system_ctrl dut (
    .clk     (clk),
    .reset   (reset),
    .req_i   (req_i),
    .we_i    (we_i),
    .size_i  (size_i),
    .sext_i  (sext_i),
    .addr_i  (addr_i),
    .wdata_i (wdata_i),
    .busy_o  (busy_o),
    .valid_o (valid_o),
    .rdata_o (rdata_o),
    .fault_o (fault_o)
  );

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        sext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_fault;
    int          exp_lat;
  } vec_t;

  vec_t vecs[$];
  int   total = 0;
  int   bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic issue(input logic we, input logic [1:0] size, input logic sext,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       output logic [31:0] rd, output logic [1:0] flt, output int lat);
    @(negedge clk);
    we_i = we; size_i = size; sext_i = sext; addr_i = addr; wdata_i = wdata;
    req_i = 1'b1;
    @(negedge clk);
    req_i = 1'b0;
    we_i = 1'($urandom); addr_i = $urandom; wdata_i = $urandom; size_i = 2'($urandom);
    lat = 1;
    while (!valid_o && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    rd  = rdata_o;
    flt = fault_o;
  endtask

  initial begin
    logic [31:0] rd;
    logic [1:0]  flt;
    int          lat;
    int          nval;
    logic [31:0] seen;

    //            we    size   sext  addr           wdata          exp_rdata      flt    lat
    vecs.push_back('{1'b0, 2'b10, 1'b0, 32'h0040_0004, 32'h0,         32'h2009_0005, 2'b00, 2});
    vecs.push_back('{1'b1, 2'b10, 1'b0, 32'h1001_0008, 32'hAABB_CCDD, 32'h0,         2'b00, 3});
    vecs.push_back('{1'b1, 2'b00, 1'b0, 32'h1001_000A, 32'h0000_0011, 32'h0,         2'b00, 3});
    vecs.push_back('{1'b0, 2'b10, 1'b0, 32'h1001_0008, 32'h0,         32'hAA11_CCDD, 2'b00, 3});
    vecs.push_back('{1'b0, 2'b00, 1'b1, 32'h1001_000B, 32'h0,         32'hFFFF_FFAA, 2'b00, 3});
    vecs.push_back('{1'b0, 2'b00, 1'b0, 32'h1001_000B, 32'h0,         32'h0000_00AA, 2'b00, 3});
    vecs.push_back('{1'b0, 2'b01, 1'b1, 32'h1001_000A, 32'h0,         32'hFFFF_AA11, 2'b00, 3});
    vecs.push_back('{1'b0, 2'b10, 1'b0, 32'h1001_0002, 32'h0,         32'h0,         2'b01, 1});
    vecs.push_back('{1'b0, 2'b10, 1'b0, 32'h1001_0100, 32'h0,         32'h0,         2'b10, 1});
    vecs.push_back('{1'b0, 2'b10, 1'b0, 32'h0000_0000, 32'h0,         32'h0,         2'b10, 1});
    vecs.push_back('{1'b1, 2'b10, 1'b0, 32'h0040_0000, 32'hDEAD_BEEF, 32'h0,         2'b11, 1});
    vecs.push_back('{1'b0, 2'b10, 1'b0, 32'h0040_0000, 32'h0,         32'h2008_0001, 2'b00, 2});
    vecs.push_back('{1'b0, 2'b01, 1'b0, 32'h1001_000B, 32'h0,         32'h0,         2'b01, 1});
    vecs.push_back('{1'b1, 2'b10, 1'b0, 32'h0040_0002, 32'h1,         32'h0,         2'b01, 1});
    vecs.push_back('{1'b0, 2'b10, 1'b0, 32'h0040_00FC, 32'h0,         32'h2047_00FD, 2'b00, 2});
    vecs.push_back('{1'b0, 2'b10, 1'b0, 32'h0040_0100, 32'h0,         32'h0,         2'b10, 1});
    vecs.push_back('{1'b1, 2'b10, 1'b0, 32'h1001_00FC, 32'h5566_7788, 32'h0,         2'b00, 3});
    vecs.push_back('{1'b0, 2'b01, 1'b0, 32'h1001_00FE, 32'h0,         32'h0000_5566, 2'b00, 3});
    vecs.push_back('{1'b0, 2'b00, 1'b1, 32'h1001_00FC, 32'h0,         32'hFFFF_FF88, 2'b00, 3});
    vecs.push_back('{1'b1, 2'b10, 1'b0, 32'h1001_0000, 32'hCAFE_F00D, 32'h0,         2'b00, 3});

    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_valid", 32'(valid_o), 32'd0);
    check("rst_rdata", rdata_o, 32'h0);
    check("rst_fault", 32'(fault_o), 32'd0);
    reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      issue(vecs[i].we, vecs[i].size, vecs[i].sext, vecs[i].addr, vecs[i].wdata, rd, flt, lat);
      check($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rdata);
      check($sformatf("v%0d_fault", i), 32'(flt), 32'(vecs[i].exp_fault));
      check($sformatf("v%0d_lat", i), 32'(lat), 32'(vecs[i].exp_lat));
      @(negedge clk);
      check($sformatf("v%0d_valid_drop", i), 32'({valid_o, busy_o}), 32'd0);
    end

    // Reset during the WAIT cycle of a store: no response, RAM keeps the old word.
    @(negedge clk);
    we_i = 1'b1; size_i = 2'b10; addr_i = 32'h1001_0000; wdata_i = 32'h1234_5678; req_i = 1'b1;
    @(negedge clk);
    req_i = 1'b0;
    check("rstmid_busy", 32'(busy_o), 32'd1);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    nval = 0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (valid_o) nval++;
    end
    check("rstmid_no_valid", 32'(nval), 32'd0);
    check("rstmid_idle", 32'(busy_o), 32'd0);
    issue(1'b0, 2'b10, 1'b0, 32'h1001_0000, 32'h0, rd, flt, lat);
    check("rstmid_old_word", rd, 32'hCAFE_F00D);
    check("rstmid_old_lat", 32'(lat), 32'd3);

    // A request pulsed while busy is ignored.
    @(negedge clk);
    we_i = 1'b0; size_i = 2'b10; sext_i = 1'b0; addr_i = 32'h1001_0008; req_i = 1'b1;
    nval = 0;
    seen = 32'h0;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (valid_o) begin
        nval++;
        seen = rdata_o;
      end
      if (n == 1) begin
        req_i = 1'b1;
        addr_i = 32'h0040_0004;
      end else begin
        req_i = 1'b0;
      end
    end
    check("busyreq_count", 32'(nval), 32'd1);
    check("busyreq_rdata", seen, 32'hAA11_CCDD);

    // req_i held high: ROM loads respond every 3 cycles, IDLE between them.
    @(negedge clk);
    we_i = 1'b0; size_i = 2'b10; addr_i = 32'h0040_0004; req_i = 1'b1;
    for (int n = 1; n <= 14; n++) begin
      @(negedge clk);
      check($sformatf("b2b_valid_%0d", n), 32'(valid_o), 32'((n % 3 == 2) && (n <= 11)));
      if (valid_o) check($sformatf("b2b_rdata_%0d", n), rdata_o, 32'h2009_0005);
      if ((n % 3 == 0) && (n <= 12)) check($sformatf("b2b_idle_%0d", n), 32'(busy_o), 32'd0);
      if (n == 10) req_i = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
